// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-stage types and sizes: physical tag width, architectural
// register count and free-list geometry, plus the pointer-to-index helper.
package phys_reg_free_list_pkg;

  localparam int PHYS_TAG_W = 6;
  localparam int ARCH_REGS  = 32;
  localparam int FREE_DEPTH = 32;  // 2**PHYS_TAG_W - ARCH_REGS, power of two
  localparam int FREE_IDX_W = $clog2(FREE_DEPTH);

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  // Pointer = array index plus one wrap bit; arithmetic is modulo 2*FREE_DEPTH.
  typedef logic [FREE_IDX_W:0]   free_ptr_t;
  typedef logic [FREE_IDX_W-1:0] free_idx_t;

  // Array slot addressed by a wrap-bit pointer.
  function automatic free_idx_t ptr_index(input free_ptr_t ptr);
    return ptr[FREE_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Renamer <-> free list handshake. The renamer (master) drives the controls
// and the returned tag; the free list (slave) publishes head tag and status.
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic      en;
  logic      rewind;
  logic      take;
  phys_tag_t takeTag;
  logic      takeValid;
  logic      commitTake;
  logic      put;
  phys_tag_t putTag;
  free_ptr_t freeCount;
  logic      overflow;

  modport master (
    output en, rewind, take, commitTake, put, putTag,
    input  takeTag, takeValid, freeCount, overflow
  );

  modport slave (
    input  en, rewind, take, commitTake, put, putTag,
    output takeTag, takeValid, freeCount, overflow
  );

endinterface

// File: rtl/phys_reg_free_list_free_tag_ram.sv
// Tag storage for the free list: one synchronous write port, one
// asynchronous read port. Reset preloads entry i with tag ARCH_REGS+i so the
// list starts full of the tags not used by the initial architectural mapping.
module free_tag_ram
  import phys_reg_free_list_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en,
  input  free_idx_t wr_addr,
  input  phys_tag_t wr_data,
  input  free_idx_t rd_addr,
  output phys_tag_t rd_data
);

  phys_tag_t mem [FREE_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < FREE_DEPTH; gi++) begin : g_entry
      // Per-entry register: async preload on reset, written when addressed.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem[gi] <= phys_tag_t'(ARCH_REGS + gi);
        end else if (wr_en && (wr_addr == free_idx_t'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags. take_ptr advances on
// speculative allocation, commit_ptr on commit, put_ptr on release. A rewind
// snaps take_ptr back to commit_ptr so every uncommitted tag is reusable at
// once. Puts are bounded against commit_ptr so the uncommitted window
// commit_ptr..take_ptr is never overwritten.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  phys_reg_free_list_if.slave   bus
);

  free_ptr_t take_ptr;
  free_ptr_t commit_ptr;
  free_ptr_t put_ptr;
  logic      overflow_reg;

  free_ptr_t free_count;
  free_ptr_t put_gap;
  logic      take_ok;
  logic      commit_ok;
  logic      put_live;
  logic      put_room;
  logic      put_ok;
  free_ptr_t commit_next;
  phys_tag_t head_tag;

  assign free_count = put_ptr - take_ptr;
  assign put_gap    = put_ptr - commit_ptr;

  // A tag written this cycle only becomes visible after the edge, because
  // free_count is computed from registered pointers (no bypass).
  assign take_ok   = bus.en && bus.take && (free_count != '0) && !bus.rewind;
  assign commit_ok = bus.en && bus.commitTake && (commit_ptr != take_ptr);
  assign put_live  = bus.en && bus.put && (bus.putTag != '0);
  assign put_room  = put_gap < free_ptr_t'(FREE_DEPTH);
  assign put_ok    = put_live && put_room;

  assign commit_next = commit_ok ? commit_ptr + free_ptr_t'(1) : commit_ptr;

  // Pointer and error-flag update; a rewind takes the post-commit position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      take_ptr     <= '0;
      commit_ptr   <= '0;
      put_ptr      <= free_ptr_t'(FREE_DEPTH);
      overflow_reg <= 1'b0;
    end else begin
      commit_ptr <= commit_next;
      if (bus.en && bus.rewind) begin
        take_ptr <= commit_next;
      end else if (take_ok) begin
        take_ptr <= take_ptr + free_ptr_t'(1);
      end
      if (put_ok) begin
        put_ptr <= put_ptr + free_ptr_t'(1);
      end
      if (put_live && !put_room) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  free_tag_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (put_ok),
    .wr_addr (ptr_index(put_ptr)),
    .wr_data (bus.putTag),
    .rd_addr (ptr_index(take_ptr)),
    .rd_data (head_tag)
  );

  assign bus.takeTag   = head_tag;
  assign bus.takeValid = (free_count != '0);
  assign bus.freeCount = free_count;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: reset values, in-order allocation,
// rewind, wrap-around refill, illegal puts and enable freeze.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  phys_reg_free_list_if bus ();

  phys_reg_free_list dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en = 1'b1;
    bus.rewind = 1'b0;
    bus.take = 1'b0;
    bus.commitTake = 1'b0;
    bus.put = 1'b0;
    bus.putTag = '0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset = 1'b0;
    idle_inputs();
    #12;

    // Reset values
    check("rst_valid", int'(bus.takeValid), 1);
    check("rst_tag", int'(bus.takeTag), 32);
    check("rst_count", int'(bus.freeCount), 32);
    check("rst_ovf", int'(bus.overflow), 0);
    reset = 1'b1;
    tick();

    // 32 consecutive takes return 32..63 in order, then a 33rd is refused
    bus.take = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("take_tag%0d", i), int'(bus.takeTag), 32 + i);
      tick();
    end
    check("empty_valid", int'(bus.takeValid), 0);
    check("empty_count", int'(bus.freeCount), 0);
    tick();
    check("take33_count", int'(bus.freeCount), 0);
    check("take33_valid", int'(bus.takeValid), 0);
    bus.take = 1'b0;

    // Reset asserted between edges takes effect without a clock
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_tag", int'(bus.takeTag), 32);
    check("async_count", int'(bus.freeCount), 32);
    check("async_valid", int'(bus.takeValid), 1);
    #1;
    reset = 1'b1;
    tick();

    // Take 5, commit 2, rewind
    bus.take = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rw_take%0d", i), int'(bus.takeTag), 32 + i);
      tick();
    end
    bus.take = 1'b0;
    bus.commitTake = 1'b1;
    tick();
    tick();
    bus.commitTake = 1'b0;
    bus.rewind = 1'b1;
    tick();
    bus.rewind = 1'b0;
    check("rw_tag", int'(bus.takeTag), 34);
    check("rw_count", int'(bus.freeCount), 30);
    // take 34, 35 then rewind + take + commit together
    bus.take = 1'b1;
    tick();
    tick();
    bus.rewind = 1'b1;
    bus.commitTake = 1'b1;
    tick();
    idle_inputs();
    check("rw2_tag", int'(bus.takeTag), 35);
    check("rw2_count", int'(bus.freeCount), 29);

    // Wrap-around refill
    pulse_reset();
    bus.take = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    bus.take = 1'b0;
    bus.commitTake = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    bus.commitTake = 1'b0;
    check("wrap_empty", int'(bus.freeCount), 0);
    bus.put = 1'b1;
    bus.putTag = 6'd40;
    bus.take = 1'b1;          // list empty: take must be ignored
    tick();
    bus.take = 1'b0;
    check("wrap_put_take_cnt", int'(bus.freeCount), 1);
    check("wrap_head0", int'(bus.takeTag), 40);
    bus.putTag = 6'd3;
    tick();
    bus.putTag = 6'd7;
    tick();
    bus.put = 1'b0;
    check("wrap_count", int'(bus.freeCount), 3);
    bus.take = 1'b1;
    check("wrap_tag_a", int'(bus.takeTag), 40);
    tick();
    check("wrap_tag_b", int'(bus.takeTag), 3);
    tick();
    check("wrap_tag_c", int'(bus.takeTag), 7);
    tick();
    bus.take = 1'b0;
    check("wrap_drained", int'(bus.freeCount), 0);
    check("wrap_ovf", int'(bus.overflow), 0);

    // Illegal puts
    pulse_reset();
    bus.put = 1'b1;
    bus.putTag = 6'd9;
    tick();
    bus.put = 1'b0;
    check("full_put_ovf", int'(bus.overflow), 1);
    check("full_put_cnt", int'(bus.freeCount), 32);
    tick();
    check("ovf_sticky", int'(bus.overflow), 1);
    pulse_reset();
    check("ovf_cleared", int'(bus.overflow), 0);
    bus.take = 1'b1;
    tick();
    bus.take = 1'b0;
    bus.put = 1'b1;
    bus.putTag = 6'd0;
    tick();
    bus.put = 1'b0;
    check("zero_put_cnt", int'(bus.freeCount), 31);
    check("zero_put_ovf", int'(bus.overflow), 0);

    // en=0 freezes state even with every control asserted
    bus.commitTake = 1'b1;
    tick();
    bus.en = 1'b0;
    bus.take = 1'b1;
    bus.put = 1'b1;
    bus.putTag = 6'd5;
    bus.rewind = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("frz_cnt%0d", i), int'(bus.freeCount), 31);
      check($sformatf("frz_tag%0d", i), int'(bus.takeTag), 33);
      check($sformatf("frz_ovf%0d", i), int'(bus.overflow), 0);
    end
    idle_inputs();
    bus.put = 1'b1;
    bus.putTag = 6'd5;
    tick();
    bus.put = 1'b0;
    check("unfrz_put_cnt", int'(bus.freeCount), 32);
    check("unfrz_ovf", int'(bus.overflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
